// File: rtl/btfa_serial_adder.sv
// btfa_serial_adder: trit-serial balanced-ternary adder/subtractor sharing one btfa
package btfa_pkg;
    typedef logic [1:0] trit_t;
endpackage

module btfa
    import btfa_pkg::*;
(
    input  trit_t a,
    input  trit_t b,
    input  trit_t cin,
    output trit_t sum,
    output trit_t cout
);
    logic signed [2:0] s;
    always_comb begin
        s = {a[1], a} + {b[1], b} + {cin[1], cin};
        cout = (s > 3'sd1) ? 2'b01 : (s < -3'sd1) ? 2'b11 : 2'b00;
        sum = (s > 3'sd1) ? s[1:0] + 2'd1 : (s < -3'sd1) ? s[1:0] - 2'd1 : s[1:0];
    end
endmodule

module btfa_serial_adder
    import btfa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  trit_t [WIDTH-1:0]       a,
    input  trit_t [WIDTH-1:0]       b,
    input  trit_t                   cin,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output trit_t [WIDTH-1:0]       sum,
    output trit_t                   cout,
    output logic                    busy
);
    localparam int SW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [SW-1:0] step;
    trit_t [WIDTH-1:0] a_q, b_q;
    trit_t carry, fa_sum, fa_cout;
    btfa u_fa (.a(a_q[step]), .b(b_q[step]), .cin(carry), .sum(fa_sum), .cout(fa_cout));
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step <= '0;
            carry <= '0;
            sum <= '0;
            cout <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    // balanced-ternary negation is a per-trit sign flip
                    for (int i = 0; i < WIDTH; i++) b_q[i] <= sub ? 2'b00 - b[i] : b[i];
                    carry <= cin;
                    step <= '0;
                    sum <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum[step] <= fa_sum;
                    carry <= fa_cout;
                    step <= step + 1'b1;
                    if (step == SW'(WIDTH - 1)) begin
                        cout <= fa_cout;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_btfa_serial_adder.sv
// tb_btfa_serial_adder: directed checks of the WIDTH=4 trit-serial adder
module tb_btfa_serial_adder;
    import btfa_pkg::*;
    localparam int W = 4;
    logic clk = 0, rst = 1, in_valid = 0, sub = 0, out_ready = 0;
    logic in_ready, out_valid, busy;
    trit_t [W-1:0] a = '0, b = '0, sum;
    trit_t cin = '0, cout;
    int tests = 0, fails = 0;

    btfa_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic issue(input trit_t [W-1:0] av, input trit_t [W-1:0] bv, input trit_t c,
                         input logic s, output int lat);
        @(negedge clk);
        a = av; b = bv; cin = c; sub = s; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            fails++; $display("FAIL reset_flags got %b exp 100", {in_ready, out_valid, busy});
        end
        tests++;
        if ({sum, cout} !== 10'b0) begin
            fails++; $display("FAIL reset_data got %b exp 0", {sum, cout});
        end
    endtask

    task automatic test_add_basic();
        int lat;
        issue(8'b00_01_01_01, 8'b01_11_11_11, 2'b00, 0, lat);
        tests++;
        if (lat !== W) begin fails++; $display("FAIL latency got %0d exp %0d", lat, W); end
        tests++;
        if (sum !== 8'b01_00_00_00 || cout !== 2'b00) begin
            fails++; $display("FAIL add_13_14 got %b/%b exp 01000000/00", sum, cout);
        end
        pop();
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            fails++; $display("FAIL pop_idle got %b exp 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_overflow();
        int lat;
        issue(8'b01_01_01_01, 8'b00_00_00_01, 2'b00, 0, lat);
        tests++;
        if (sum !== 8'b11_11_11_11 || cout !== 2'b01) begin
            fails++; $display("FAIL add_40_1 got %b/%b exp 11111111/01", sum, cout);
        end
        pop();
        issue(8'b11_11_11_11, 8'b11_11_11_11, 2'b11, 0, lat);
        tests++;
        if (sum !== 8'b00_00_00_00 || cout !== 2'b11) begin
            fails++; $display("FAIL add_m40_m40_m1 got %b/%b exp 00000000/11", sum, cout);
        end
        pop();
    endtask

    task automatic test_sub();
        int lat;
        issue(8'b00_01_11_11, 8'b00_01_01_00, 2'b00, 1, lat);
        tests++;
        if (sum !== 8'b00_11_01_11 || cout !== 2'b00) begin
            fails++; $display("FAIL sub_5_12 got %b/%b exp 00110111/00", sum, cout);
        end
        pop();
        issue(8'b00_00_00_01, 8'b00_00_01_11, 2'b01, 1, lat);
        tests++;
        if (sum !== 8'b00_00_00_00 || cout !== 2'b00) begin
            fails++; $display("FAIL sub_1_2_cin1 got %b/%b exp 00000000/00", sum, cout);
        end
        pop();
    endtask

    task automatic test_hold();
        int lat;
        logic bad = 0;
        issue(8'b00_01_01_01, 8'b01_11_11_11, 2'b00, 0, lat);
        a = 8'b01_01_01_01; b = 8'b01_01_01_01; in_valid = 1;
        repeat (6) begin
            @(negedge clk);
            if (sum !== 8'b01_00_00_00 || cout !== 2'b00 || {in_ready, out_valid, busy} !== 3'b011)
                bad = 1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL hold_stable got %b/%b/%b exp 01000000/00/011", sum, cout,
                              {in_ready, out_valid, busy});
        end
        in_valid = 0;
        pop();
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            fails++; $display("FAIL hold_release got %b exp 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        a = 8'b01_01_01_01; b = 8'b01_01_01_01; cin = 2'b00; sub = 0; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100 || {sum, cout} !== 10'b0) begin
            fails++; $display("FAIL mid_reset got %b/%b exp 100/0", {in_ready, out_valid, busy},
                              {sum, cout});
        end
        issue(8'b00_00_00_01, 8'b00_00_00_01, 2'b00, 0, lat);
        tests++;
        if (sum !== 8'b00_00_01_11 || cout !== 2'b00 || lat !== W) begin
            fails++; $display("FAIL after_reset_1_1 got %b/%b lat %0d exp 00000111/00 lat %0d",
                              sum, cout, lat, W);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'b00_00_00_01, 8'b00_00_00_00, 2'b01, 0, lat);
        tests++;
        if (sum !== 8'b00_00_01_11 || cout !== 2'b00) begin
            fails++; $display("FAIL b2b_first got %b/%b exp 00000111/00", sum, cout);
        end
        pop();
        issue(8'b01_00_00_00, 8'b01_00_00_00, 2'b00, 1, lat);
        tests++;
        if (sum !== 8'b00_00_00_00 || cout !== 2'b00 || lat !== W) begin
            fails++; $display("FAIL b2b_second got %b/%b lat %0d exp 00000000/00 lat %0d",
                              sum, cout, lat, W);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_overflow();
        test_sub();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
